sram_controller: RTL and testbench
==================================

Name: sram_controller

Overview:
Sequences multi-cycle accesses from the pipeline MEM stage to an external 16-bit asynchronous SRAM that stores the 32-bit data memory. Each 32-bit load or store is split into two 16-bit half accesses, low half first. While an access is in flight, `ready` is held low, and the top level uses `~ready` to freeze every pipeline register and the PC. The block replaces the single-cycle data memory in the MEM stage.

Parameters:
- WAIT_CYCLES, 2: cycles spent on each 16-bit half access; legal range 2..15.
- BASE_ADDR, 1024: byte address that maps to SRAM word 0.
- SRAM_AW, 18: width of the SRAM half-word address.

Ports:
- clk  in  1  system clock, rising edge.
- rst  in  1  reset, asynchronous, active-low; clears all state.
- rd_en  in  1  load request from MEM stage; level, held until `ready`.
- wr_en  in  1  store request from MEM stage; level, held until `ready`.
- address  in  32  byte address from the ALU result.
- writeData  in  32  store value.
- readData  out  32  load result; valid in the cycle `ready` rises, then held.
- ready  out  1  high means no access is in flight; low means freeze the pipeline.
- sram_addr  out  SRAM_AW  SRAM half-word address.
- sram_dq_out  out  16  write data to the SRAM pad driver.
- sram_dq_in  in  16  read data from the SRAM pad.
- sram_dq_oe  out  1  pad output enable.
- sram_we_n  out  1  SRAM write strobe, active-low.

Behaviour:
- Reset values: state IDLE, readData 0, ready 1, sram_addr 0, sram_dq_out 0, sram_dq_oe 0, sram_we_n 1, internal counter 0.
- Address map: word = (address - BASE_ADDR) >> 2. Low half goes to sram_addr = {word, 0}, high half to {word, 1}. Bits above SRAM_AW are truncated.
- Request: req = rd_en | wr_en. If both are high, the access is a write; reads are ignored.
- `ready` is combinational: 0 when (state == IDLE and req), or when state is LOW or HIGH; 1 otherwise.
- IDLE:
  - On req, latch address, writeData and the op, clear the counter, go to LOW.
  - Otherwise stay in IDLE; SRAM outputs are idle (we_n=1, oe=0).
- LOW, for WAIT_CYCLES cycles:
  - Drive the low-half address.
  - Write: sram_dq_out = data[15:0], oe=1; sram_we_n=0 for counter < WAIT_CYCLES-1 and 1 on the last cycle.
  - Read: on the last cycle, capture sram_dq_in into a low-half buffer.
  - After the last cycle, clear the counter and go to HIGH.
- HIGH: same as LOW but for the high half, using data[31:16]. On its last cycle a read loads readData = {sram_dq_in, low buffer}. Then go to DONE.
- DONE, one cycle:
  - ready=1, SRAM outputs idle; the pipeline advances on this edge.
  - Next state is IDLE unconditionally, so a held req is not re-served.
- Timing: ready is low for exactly 2*WAIT_CYCLES+1 cycles per access, followed by exactly one ready-high cycle (DONE).
- Back-to-back accesses: the next request is accepted in the IDLE cycle after DONE.
- Request inputs changing after acceptance are ignored; the latched values are used.
- A write never modifies readData.
- Reset asserted mid-access aborts the access: state IDLE, sram_we_n=1 immediately (asynchronous), and the partial write is not retried.
- Counter is 4 bits wide; WAIT_CYCLES outside 2..15 is an elaboration error.

Optional Feature:
SRAM_CTRL_RANGE_CHECK_EN
- Enabled:
  - Adds output port addr_err (1 bit, reset 0).
  - An address below BASE_ADDR, or one whose word index exceeds 2^(SRAM_AW-1)-1, is not issued to the SRAM.
  - The block goes IDLE→DONE directly: ready low 1 cycle, addr_err=1 for the DONE cycle, readData set to 0 for loads.
- Disabled: no addr_err port; out-of-range addresses wrap modulo the SRAM size per the truncation rule.

Decomposition:
- Shared package (sram_pkg): state enum IDLE/LOW/HIGH/DONE, SRAM_DW=16, default BASE_ADDR, and the address-map function.
- One natural sub-module: sram_wait_counter. It counts 0..WAIT_CYCLES-1, with clear, enable and a last-cycle flag, and is instantiated once.

Test Plan (WAIT_CYCLES=2, BASE_ADDR=1024):
1. Reset released with no request → ready=1, sram_we_n=1, sram_dq_oe=0, readData=0.
2. wr_en=1, address=1032, writeData=0xDEADBEEF:
   - ready low for 5 cycles.
   - sram_addr=4 carries 0xBEEF with we_n low for 1 cycle, then sram_addr=5 carries 0xDEAD with we_n low for 1 cycle.
   - ready=1 in cycle 5.
3. After test 2, rd_en=1, address=1032, SRAM model returning the stored values → readData=0xDEADBEEF in the ready-high cycle; readData is held after rd_en drops.
4. rd_en and wr_en both high, address=1036, writeData=0x12345678 → a write is performed (half-words 6 and 7); readData is unchanged.
5. rst asserted during the HIGH state of a write → sram_we_n=1 in the same cycle, ready=1, state IDLE; a subsequent read of half-word 7 returns the pre-write value.
6. With SRAM_CTRL_RANGE_CHECK_EN and rd_en at address=512 → ready low for 1 cycle, addr_err=1, readData=0, no SRAM activity.

Source files
------------

// File: rtl/sram_pkg.sv
`default_nettype none
// ============================================================================
//  Module      : sram_pkg
//  Description : Shared types, constants and address-map helpers for the
//                16-bit asynchronous SRAM data-memory controller.
//  Revision    : 1.0 - initial release
// ============================================================================
package sram_pkg;

    localparam int SRAM_DW           = 16;
    localparam int DEFAULT_BASE_ADDR = 1024;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        LOW  = 2'd1,
        HIGH = 2'd2,
        DONE = 2'd3
    } state_t;

    // 32-bit word index of a byte address relative to the SRAM window base
    function automatic logic [31:0] word_index(input logic [31:0] byte_addr,
                                               input logic [31:0] base_addr);
        return (byte_addr - base_addr) >> 2;
    endfunction

    // Half-word address {word, hi}; the caller truncates to the SRAM width
    function automatic logic [31:0] half_addr(input logic [31:0] byte_addr,
                                              input logic [31:0] base_addr,
                                              input logic        hi);
        logic [31:0] w_word;
        w_word = word_index(byte_addr, base_addr);
        return {w_word[30:0], hi};
    endfunction

endpackage
`default_nettype wire

// File: rtl/sram_wait_counter.sv
`default_nettype none
// ============================================================================
//  Module      : sram_wait_counter
//  Description : Per-half-access wait counter. Counts 0..WAIT_CYCLES-1 while
//                enabled, wraps to 0 after the last cycle, flags the last
//                cycle. Synchronous clear has priority over enable.
//  Revision    : 1.0 - initial release
// ============================================================================
module sram_wait_counter #(
    parameter int WAIT_CYCLES = 2
) (
    input  logic clk,
    input  logic rst,      // asynchronous, active-low
    input  logic clear,
    input  logic enable,
    output logic last
);

    localparam logic [3:0] c_LAST = 4'(WAIT_CYCLES - 1);

    // The 4-bit counter only covers 2..15 wait cycles
    generate
        if (WAIT_CYCLES < 2 || WAIT_CYCLES > 15) begin : g_bad_wait
            $error("sram_wait_counter: WAIT_CYCLES must be in 2..15");
        end
    endgenerate

    logic [3:0] r_count;

    // Count through one half access, wrapping after the last cycle
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_count <= 4'd0;
        end else if (clear) begin
            r_count <= 4'd0;
        end else if (enable) begin
            r_count <= (r_count == c_LAST) ? 4'd0 : r_count + 4'd1;
        end
    end

    assign last = (r_count == c_LAST);

endmodule
`default_nettype wire

// File: rtl/sram_controller.sv
`default_nettype none
// ============================================================================
//  Module      : sram_controller
//  Description : MEM-stage data memory front end for a 16-bit asynchronous
//                SRAM. Each 32-bit load/store is split into two half-word
//                accesses (low half first); ready is low while an access is
//                in flight so the pipeline can be frozen.
//                Optional build macro SRAM_CTRL_RANGE_CHECK_EN adds the
//                addr_err port and rejects addresses outside the SRAM window.
//  Revision    : 1.0 - initial release
// ============================================================================
module sram_controller
    import sram_pkg::*;
#(
    parameter int WAIT_CYCLES = 2,
    parameter int BASE_ADDR   = DEFAULT_BASE_ADDR,
    parameter int SRAM_AW     = 18
) (
    input  logic                 clk,
    input  logic                 rst,          // asynchronous, active-low
    input  logic                 rd_en,
    input  logic                 wr_en,
    input  logic [31:0]          address,
    input  logic [31:0]          writeData,
    output logic [31:0]          readData,
    output logic                 ready,
    output logic [SRAM_AW-1:0]   sram_addr,
    output logic [SRAM_DW-1:0]   sram_dq_out,
    input  logic [SRAM_DW-1:0]   sram_dq_in,
    output logic                 sram_dq_oe,
    output logic                 sram_we_n
`ifdef SRAM_CTRL_RANGE_CHECK_EN
    ,
    output logic                 addr_err
`endif
);

    localparam logic [31:0] c_BASE = 32'(BASE_ADDR);

    state_t               r_state;
    state_t               w_next_state;
    logic [31:0]          r_addr;
    logic [31:0]          r_wdata;
    logic                 r_is_write;
    logic [SRAM_DW-1:0]   r_low_buf;
    logic [31:0]          r_read_data;

    logic                 w_req;
    logic                 w_addr_bad;
    logic                 w_cnt_clear;
    logic                 w_cnt_en;
    logic                 w_cnt_last;
    logic [SRAM_AW-1:0]   w_lo_addr;
    logic [SRAM_AW-1:0]   w_hi_addr;

    assign w_req = rd_en | wr_en;

`ifdef SRAM_CTRL_RANGE_CHECK_EN
    localparam logic [31:0] c_MAX_WORD = 32'((64'd1 << (SRAM_AW - 1)) - 64'd1);
    assign w_addr_bad = (address < c_BASE) || (word_index(address, c_BASE) > c_MAX_WORD);
`else
    // Out-of-window addresses simply wrap through address truncation
    assign w_addr_bad = 1'b0;
`endif

    assign w_lo_addr = SRAM_AW'(half_addr(r_addr, c_BASE, 1'b0));
    assign w_hi_addr = SRAM_AW'(half_addr(r_addr, c_BASE, 1'b1));

    // Counter is parked at zero whenever no half access is running
    assign w_cnt_clear = (r_state == IDLE);
    assign w_cnt_en    = (r_state == LOW) || (r_state == HIGH);

    sram_wait_counter #(
        .WAIT_CYCLES (WAIT_CYCLES)
    ) u_wait_counter (
        .clk    (clk),
        .rst    (rst),
        .clear  (w_cnt_clear),
        .enable (w_cnt_en),
        .last   (w_cnt_last)
    );

    // State register; reset aborts any access in flight
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_state <= IDLE;
        end else begin
            r_state <= w_next_state;
        end
    end

    // Next state, ready and SRAM pin decode; SRAM pins idle unless in a half
    always_comb begin
        w_next_state = r_state;
        ready        = 1'b1;
        sram_addr    = '0;
        sram_dq_out  = '0;
        sram_dq_oe   = 1'b0;
        sram_we_n    = 1'b1;
        case (r_state)
            IDLE: begin
                if (w_req) begin
                    ready        = 1'b0;
                    w_next_state = w_addr_bad ? DONE : LOW;
                end
            end
            LOW: begin
                ready       = 1'b0;
                sram_addr   = w_lo_addr;
                sram_dq_out = r_is_write ? r_wdata[15:0] : '0;
                sram_dq_oe  = r_is_write;
                // Strobe released on the last cycle gives data hold time
                sram_we_n   = ~(r_is_write & ~w_cnt_last);
                if (w_cnt_last) begin
                    w_next_state = HIGH;
                end
            end
            HIGH: begin
                ready       = 1'b0;
                sram_addr   = w_hi_addr;
                sram_dq_out = r_is_write ? r_wdata[31:16] : '0;
                sram_dq_oe  = r_is_write;
                sram_we_n   = ~(r_is_write & ~w_cnt_last);
                if (w_cnt_last) begin
                    w_next_state = DONE;
                end
            end
            DONE: begin
                // Unconditional return so a still-held request is not re-served
                w_next_state = IDLE;
            end
            default: begin
                w_next_state = IDLE;
            end
        endcase
    end

    // Request latch and read-data assembly
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_addr      <= '0;
            r_wdata     <= '0;
            r_is_write  <= 1'b0;
            r_low_buf   <= '0;
            r_read_data <= '0;
        end else begin
            if (r_state == IDLE && w_req) begin
                r_addr     <= address;
                r_wdata    <= writeData;
                r_is_write <= wr_en;
                if (w_addr_bad && !wr_en) begin
                    r_read_data <= '0;
                end
            end
            if (r_state == LOW && w_cnt_last && !r_is_write) begin
                r_low_buf <= sram_dq_in;
            end
            if (r_state == HIGH && w_cnt_last && !r_is_write) begin
                r_read_data <= {sram_dq_in, r_low_buf};
            end
        end
    end

    assign readData = r_read_data;

`ifdef SRAM_CTRL_RANGE_CHECK_EN
    logic r_addr_err;

    // Error flag is high only for the DONE cycle of a rejected access
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_addr_err <= 1'b0;
        end else begin
            r_addr_err <= (r_state == IDLE) && w_req && w_addr_bad;
        end
    end

    assign addr_err = r_addr_err;
`endif

endmodule
`default_nettype wire

// File: tb/tb_sram_controller.sv
`default_nettype none
// ============================================================================
//  Module      : tb_sram_controller
//  Description : Self-checking bench for sram_controller with a behavioural
//                SRAM and a half-word reference memory.
//  Revision    : 1.0 - initial release
// ============================================================================
module tb_sram_controller;

    localparam int c_WAIT  = 2;
    localparam int c_BASE  = 1024;
    localparam int c_AW    = 18;
    localparam int c_DEPTH = 1 << c_AW;

    logic              clk       = 1'b0;
    logic              rst       = 1'b0;
    logic              rd_en     = 1'b0;
    logic              wr_en     = 1'b0;
    logic [31:0]       address   = '0;
    logic [31:0]       writeData = '0;
    logic [31:0]       readData;
    logic              ready;
    logic [c_AW-1:0]   sram_addr;
    logic [15:0]       sram_dq_out;
    logic [15:0]       sram_dq_in;
    logic              sram_dq_oe;
    logic              sram_we_n;
`ifdef SRAM_CTRL_RANGE_CHECK_EN
    logic              addr_err;
`endif

    sram_controller #(
        .WAIT_CYCLES (c_WAIT),
        .BASE_ADDR   (c_BASE),
        .SRAM_AW     (c_AW)
    ) dut (
        .clk         (clk),
        .rst         (rst),
        .rd_en       (rd_en),
        .wr_en       (wr_en),
        .address     (address),
        .writeData   (writeData),
        .readData    (readData),
        .ready       (ready),
        .sram_addr   (sram_addr),
        .sram_dq_out (sram_dq_out),
        .sram_dq_in  (sram_dq_in),
        .sram_dq_oe  (sram_dq_oe),
        .sram_we_n   (sram_we_n)
`ifdef SRAM_CTRL_RANGE_CHECK_EN
        ,
        .addr_err    (addr_err)
`endif
    );

    always #5 clk = ~clk;

    // Behavioural SRAM and the reference image of what it should hold
    logic [15:0] sram_mem [c_DEPTH];
    logic [15:0] ref_mem  [c_DEPTH];
    logic [31:0] ref_rd;
    int          n_cmp      = 0;
    int          n_err      = 0;
    int          we_cycles  = 0;
    int          oe_cycles  = 0;

    assign sram_dq_in = sram_mem[sram_addr];

    always @(posedge clk) begin
        if (!sram_we_n) begin
            sram_mem[sram_addr] = sram_dq_out;
        end
    end

    always @(posedge clk) begin
        if (!sram_we_n) we_cycles <= we_cycles + 1;
        if (sram_dq_oe) oe_cycles <= oe_cycles + 1;
    end

    task automatic check_val(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
        end
    endtask

    // Half-word index of a byte address: word*2+hi, modulo the SRAM size
    function automatic int ref_half(input logic [31:0] addr, input int hi);
        logic [31:0]     diff;
        longint unsigned word;
        diff = addr - 32'(c_BASE);
        word = longint'(diff / 4);
        return int'((word * 2 + longint'(hi)) % c_DEPTH);
    endfunction

    task automatic do_access(input bit rd, input bit wr, input logic [31:0] addr,
                             input logic [31:0] data, input bit scramble);
        int cnt;
        int we0;
        int oe0;
        int lo;
        int hi;
        lo = ref_half(addr, 0);
        hi = ref_half(addr, 1);
        @(negedge clk);
        rd_en = rd; wr_en = wr; address = addr; writeData = data;
        #1;
        we0 = we_cycles;
        oe0 = oe_cycles;
        cnt = 0;
        while (!ready && cnt < 100) begin
            cnt++;
            @(negedge clk);
            if (scramble) begin
                address   = $urandom;
                writeData = $urandom;
                rd_en     = 1'($urandom);
                wr_en     = 1'($urandom);
            end
            #1;
        end
        if (wr) begin
            ref_mem[lo] = data[15:0];
            ref_mem[hi] = data[31:16];
        end else begin
            ref_rd = {ref_mem[hi], ref_mem[lo]};
        end
        check_val("ready_low_cycles", cnt, 2 * c_WAIT + 1);
        check_val("readData_done", readData, ref_rd);
        check_val("mem_lo", sram_mem[lo], ref_mem[lo]);
        check_val("mem_hi", sram_mem[hi], ref_mem[hi]);
        check_val("we_cycles", we_cycles - we0, wr ? 2 * (c_WAIT - 1) : 0);
        check_val("oe_cycles", oe_cycles - oe0, wr ? 2 * c_WAIT : 0);
`ifdef SRAM_CTRL_RANGE_CHECK_EN
        check_val("addr_err_ok", addr_err, 1'b0);
`endif
        rd_en = 1'b0; wr_en = 1'b0;
        @(negedge clk);
        #1;
        check_val("ready_after", ready, 1'b1);
        check_val("readData_held", readData, ref_rd);
    endtask

    initial begin
        logic [15:0] v;
        int          op;
        logic [31:0] a;
        for (int i = 0; i < c_DEPTH; i++) begin
            v = 16'($urandom);
            sram_mem[i] = v;
            ref_mem[i]  = v;
        end
        ref_rd = '0;

        // Reset state
        repeat (3) @(negedge clk);
        #1;
        check_val("rst_ready", ready, 1'b1);
        check_val("rst_we_n", sram_we_n, 1'b1);
        check_val("rst_oe", sram_dq_oe, 1'b0);
        check_val("rst_readData", readData, 32'h0);
        check_val("rst_sram_addr", 32'(sram_addr), 32'h0);
        check_val("rst_dq_out", sram_dq_out, 16'h0);
`ifdef SRAM_CTRL_RANGE_CHECK_EN
        check_val("rst_addr_err", addr_err, 1'b0);
`endif
        @(negedge clk);
        rst = 1'b1;

        // Directed store, load and simultaneous request
        do_access(1'b0, 1'b1, 32'd1032, 32'hDEADBEEF, 1'b0);
        check_val("t2_half4", sram_mem[4], 16'hBEEF);
        check_val("t2_half5", sram_mem[5], 16'hDEAD);
        do_access(1'b1, 1'b0, 32'd1032, 32'h0, 1'b1);
        check_val("t3_load", readData, 32'hDEADBEEF);
        do_access(1'b1, 1'b1, 32'd1036, 32'h12345678, 1'b0);
        check_val("t4_half6", sram_mem[6], 16'h5678);
        check_val("t4_half7", sram_mem[7], 16'h1234);
        check_val("t4_readData", readData, 32'hDEADBEEF);

        // Reset during the high-half write strobe
        @(negedge clk);
        wr_en = 1'b1; address = 32'd1036; writeData = 32'hCAFEF00D;
        repeat (3) @(negedge clk);
        #1;
        check_val("t5_high_we", sram_we_n, 1'b0);
        check_val("t5_high_addr", 32'(sram_addr), 32'd7);
        rst = 1'b0; wr_en = 1'b0;
        #1;
        check_val("t5_abort_we_n", sram_we_n, 1'b1);
        check_val("t5_abort_ready", ready, 1'b1);
        check_val("t5_abort_oe", sram_dq_oe, 1'b0);
        check_val("t5_abort_readData", readData, 32'h0);
        ref_rd = '0;
        ref_mem[6] = 16'hF00D;
        @(negedge clk);
        rst = 1'b1;
        do_access(1'b1, 1'b0, 32'd1036, 32'h0, 1'b0);
        check_val("t5_readback", readData, 32'h1234F00D);

        // Randomised traffic
        for (int n = 0; n < 40; n++) begin
            op = int'($urandom_range(0, 2));
            a  = 32'(c_BASE) + 32'($urandom_range(0, (1 << (c_AW - 1)) - 1)) * 4
                 + 32'($urandom_range(0, 3));
`ifndef SRAM_CTRL_RANGE_CHECK_EN
            if (n % 8 == 7) a = $urandom;   // out-of-window wraps by truncation
`endif
            do_access(op != 1, op != 0, a, $urandom, 1'($urandom));
        end

`ifdef SRAM_CTRL_RANGE_CHECK_EN
        begin
            int we0;
            int oe0;
            @(negedge clk);
            rd_en = 1'b1; address = 32'd512;
            #1;
            we0 = we_cycles;
            oe0 = oe_cycles;
            check_val("t6_ready_low", ready, 1'b0);
            @(negedge clk);
            #1;
            check_val("t6_ready_done", ready, 1'b1);
            check_val("t6_addr_err", addr_err, 1'b1);
            check_val("t6_readData", readData, 32'h0);
            check_val("t6_no_we", we_cycles - we0, 0);
            check_val("t6_no_oe", oe_cycles - oe0, 0);
            rd_en = 1'b0;
            @(negedge clk);
            #1;
            check_val("t6_addr_err_clr", addr_err, 1'b0);
            ref_rd = '0;
        end
`endif

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
`default_nettype wire
